// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard FSM state encodings, ID/EX register image and the bubble constant.
package pipe_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  // Decision taken for the ID/EX register at the coming edge.
  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_HOLD  = 2'd3
  } hz_act_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detect and hazard priority decode (mem_stall > branch > load-use > run).
// Zero latency; mem_stall freezes the front end and the ID/EX register.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic      [4:0] id_rs1_i,
  input  logic      [4:0] id_rs2_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic      [4:0] ex_rd_i,
  input  logic            ex_mem_read_i,
  input  logic            ex_branch_taken_i,
  input  logic            mem_stall_i,
  input  hz_state_e       state_i,
  output logic            lu_o,
  output hz_act_e         act_o,
  output logic            pc_write_o,
  output logic            if_id_write_o,
  output logic            if_id_flush_o
);

  logic branch;

  // x0 as a load destination never creates a dependency.
  assign lu_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                 (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  // EX holds a bubble while in FLUSH, so a branch indication there is stale.
  assign branch = ex_branch_taken_i && (state_i != HZ_FLUSH);

  always_comb begin
    act_o         = ACT_LOAD;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    if (mem_stall_i) begin
      act_o         = ACT_HOLD;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else if (branch) begin
      act_o         = ACT_FLUSH;
      if_id_flush_o = 1'b1;
    end else if (lu_o) begin
      act_o         = ACT_STALL;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_hazard.sv
// ID/EX register with RUN/STALL/FLUSH hazard FSM; registers load one cycle after ID, bubbles on stall/flush.
// mem_stall freezes everything; optional stall_cnt counter enabled by HAZARD_PERF_CNT_EN.
module id_ex_hazard
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        ex_branch_taken,
  input  logic        mem_stall,
  output logic [4:0]  ID_EX_RegisterRs1,
  output logic [4:0]  ID_EX_RegisterRs2,
  output logic [4:0]  ID_EX_RegisterRd,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemRead,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [1:0]  hz_state
);

  hz_state_e state_q, state_d;
  idex_t     idex_q, idex_d;
  hz_act_e   act;
  logic      lu;
  logic      pc_write, if_id_write, if_id_flush;

  hazard_detect u_detect (
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_use_rs1_i      (id_use_rs1),
    .id_use_rs2_i      (id_use_rs2),
    .ex_rd_i           (idex_q.rd),
    .ex_mem_read_i     (idex_q.mem_read),
    .ex_branch_taken_i (ex_branch_taken),
    .mem_stall_i       (mem_stall),
    .state_i           (state_q),
    .lu_o              (lu),
    .act_o             (act),
    .pc_write_o        (pc_write),
    .if_id_write_o     (if_id_write),
    .if_id_flush_o     (if_id_flush)
  );

  always_comb begin
    state_d = state_q;
    idex_d  = idex_q;
    case (act)
      ACT_HOLD: ;
      ACT_FLUSH: begin
        idex_d  = IDEX_BUBBLE;
        state_d = HZ_FLUSH;
      end
      ACT_STALL: begin
        idex_d  = IDEX_BUBBLE;
        state_d = HZ_STALL;
      end
      default: begin
        idex_d  = {id_rs1, id_rs2, id_rd, id_RegWrite, id_MemRead};
        state_d = HZ_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
      idex_q  <= IDEX_BUBBLE;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Frozen cycles are not bubble insertions; wrap is natural 32-bit overflow.
  assign stall_cnt_d = ((act == ACT_FLUSH) || (act == ACT_STALL)) ? stall_cnt_q + 32'd1
                                                                  : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // Front end free-runs while reset is held, regardless of mem_stall.
  assign PCWrite     = rst | pc_write;
  assign IF_ID_Write = rst | if_id_write;
  assign IF_ID_Flush = ~rst & if_id_flush;

  assign ID_EX_RegisterRs1 = idex_q.rs1;
  assign ID_EX_RegisterRs2 = idex_q.rs2;
  assign ID_EX_RegisterRd  = idex_q.rd;
  assign ID_EX_RegWrite    = idex_q.reg_write;
  assign ID_EX_MemRead     = idex_q.mem_read;
  assign hz_state          = state_q;

endmodule
